modn_run_ctrl: RTL and testbench

Controller that sequences a programmable mod-N counter for a configured number of full periods, then reports completion. Software/upstream logic loads modulus and repeat count with a start pulse. The block then owns the counter: advance, pause, abort and terminal-count signalling. Sits between a control/config source and any logic consuming the count value or terminal-count tick.

---
 rtl/modn_run_ctrl.sv | 167 ++++++++++++++++
 tb/tb_modn_run_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/modn_run_ctrl.sv
// modn_run_ctrl: runs a programmable mod-N counter for a configured number of
// full periods, with pause and abort control.
// A one-cycle done pulse marks the end of the run.
// An err pulse flags a start request with a zero modulus or zero repeat count.
module modn_run_ctrl #(
   parameter int WIDTH = 4,
   parameter int RW    = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [WIDTH-1:0] cfg_mod,
   input  logic [RW-1:0]    cfg_reps,
   input  logic             pause,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic [RW-1:0]    rep_cnt
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] mod_q, mod_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [RW-1:0]    reps_q, reps_d;
   logic [RW-1:0]    rep_q, rep_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   logic cfgValid;
   logic active;
   logic advance;
   logic atTerm;
   logic lastRep;

   // A start request is only legal with a non-zero modulus and repeat count.
   assign cfgValid = (cfg_mod != '0) && (cfg_reps != '0);

   // The counter moves on every RUN or PAUSE cycle in which pause and abort are both low.
   // Leaving PAUSE therefore advances on the same edge, with no skipped or repeated value.
   assign active  = (state_q == RUN) || (state_q == PAUSE);
   assign advance = active && !abort && !pause;
   assign atTerm  = (count_q == (mod_q - WIDTH'(1)));
   assign lastRep = (rep_q == (reps_q - RW'(1)));

   assign tc      = advance && atTerm;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err     = err_q;
   assign count   = count_q;
   assign rep_cnt = rep_q;

   // State register; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rstn) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: abort beats pause, and pause beats the final wrap.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start && cfgValid) begin
               state_d = RUN;
            end
         end
         RUN, PAUSE: begin
            if (abort) begin
               state_d = IDLE;
            end else if (pause) begin
               state_d = PAUSE;
            end else if (atTerm && lastRep) begin
               state_d = DONE;
            end else begin
               state_d = RUN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Next values for the registered outputs and the latched configuration.
   always_comb begin
      mod_d   = mod_q;
      reps_d  = reps_q;
      count_d = count_q;
      rep_d   = rep_q;
      err_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (cfgValid) begin
                  mod_d   = cfg_mod;
                  reps_d  = cfg_reps;
                  count_d = '0;
                  rep_d   = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         RUN, PAUSE: begin
            if (abort) begin
               count_d = '0;
               rep_d   = '0;
            end else if (advance) begin
               if (atTerm) begin
                  count_d = '0;
                  rep_d   = rep_q + RW'(1);
               end else begin
                  count_d = count_q + WIDTH'(1);
               end
            end
         end
         DONE: begin
            count_d = '0;
         end
         default: begin
            count_d = '0;
         end
      endcase
      busy_d = (state_d == RUN) || (state_d == PAUSE);
      done_d = (state_d == DONE);
   end

   // Datapath and output registers, cleared together with the state register.
   always_ff @(posedge clk) begin
      if (rstn) begin
         mod_q   <= '0;
         reps_q  <= '0;
         count_q <= '0;
         rep_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         mod_q   <= mod_d;
         reps_q  <= reps_d;
         count_q <= count_d;
         rep_q   <= rep_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_modn_run_ctrl.sv
// tb_modn_run_ctrl: directed stimulus with a queue-based scoreboard.
// Each driven cycle pushes the outputs expected in that cycle.
// A monitor pops the queue on each falling edge and compares against the DUT.
module tb_modn_run_ctrl;

   logic       clk;
   logic       rstn;
   logic       start;
   logic [3:0] cfg_mod;
   logic [7:0] cfg_reps;
   logic       pause;
   logic       abort;
   logic       busy;
   logic       done;
   logic       err;
   logic [3:0] count;
   logic       tc;
   logic [7:0] rep_cnt;

   typedef struct {
      logic       busy;
      logic       done;
      logic       err;
      logic       tc;
      logic [3:0] count;
      logic [7:0] rep;
      logic       chkRep;
      int         tag;
   } exp_t;

   exp_t scoreQ[$];
   int   checks   = 0;
   int   failures = 0;
   int   cycleNo  = 0;

   modn_run_ctrl #(.WIDTH(4), .RW(8)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .start    (start),
      .cfg_mod  (cfg_mod),
      .cfg_reps (cfg_reps),
      .pause    (pause),
      .abort    (abort),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .count    (count),
      .tc       (tc),
      .rep_cnt  (rep_cnt)
   );

   // 10-unit clock period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic b, input logic d, input logic er,
                               input logic [3:0] c, input logic t,
                               input logic [7:0] rp, input logic cr);
      exp_t e;
      e.busy   = b;
      e.done   = d;
      e.err    = er;
      e.count  = c;
      e.tc     = t;
      e.rep    = rp;
      e.chkRep = cr;
      e.tag    = 0;
      return e;
   endfunction

   task automatic checkOutput(input string name, input int tag,
                              input logic [7:0] act, input logic [7:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", name, tag, act, expv);
      end
   endtask

   // Drives one cycle of inputs and records what the outputs must show in that cycle.
   task automatic applyStimulus(input logic st, input logic [3:0] m, input logic [7:0] r,
                                input logic p, input logic a, input logic rs, input exp_t e);
      start    = st;
      cfg_mod  = m;
      cfg_reps = r;
      pause    = p;
      abort    = a;
      rstn     = rs;
      e.tag    = cycleNo;
      cycleNo++;
      scoreQ.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare the DUT outputs against the oldest pending expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (scoreQ.size() > 0) begin
            e = scoreQ.pop_front();
            checkOutput("busy",  e.tag, {7'd0, busy},  {7'd0, e.busy});
            checkOutput("done",  e.tag, {7'd0, done},  {7'd0, e.done});
            checkOutput("err",   e.tag, {7'd0, err},   {7'd0, e.err});
            checkOutput("tc",    e.tag, {7'd0, tc},    {7'd0, e.tc});
            checkOutput("count", e.tag, {4'd0, count}, {4'd0, e.count});
            if (e.chkRep) begin
               checkOutput("rep_cnt", e.tag, rep_cnt, e.rep);
            end
         end
      end
   end

   // Directed scenarios.
   initial begin
      rstn     = 1'b1;
      start    = 1'b0;
      cfg_mod  = 4'd0;
      cfg_reps = 8'd0;
      pause    = 1'b0;
      abort    = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] reset state");
      applyStimulus(0, 0, 0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 1));

      $display("[TB] mod=10 reps=2 full run");
      applyStimulus(1, 10, 2, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1));
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 10; c++) begin
            applyStimulus(0, 10, 2, 0, 0, 0, mk(1, 0, 0, 4'(c), (c == 9), 8'(r), 1));
         end
      end
      applyStimulus(0, 10, 2, 0, 0, 0, mk(0, 1, 0, 0, 0, 2, 1));
      applyStimulus(0, 10, 2, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));

      $display("[TB] invalid configurations");
      applyStimulus(1, 0, 2, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
      applyStimulus(0, 0, 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0));
      applyStimulus(1, 5, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
      applyStimulus(0, 0, 0, 0, 0, 0, mk(0, 0, 1, 0, 0, 0, 0));
      applyStimulus(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));

      $display("[TB] mod=1 reps=3, start during DONE");
      applyStimulus(1, 1, 3, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
      for (int r = 0; r < 3; r++) begin
         applyStimulus(0, 1, 3, 0, 0, 0, mk(1, 0, 0, 0, 1, 8'(r), 1));
      end
      applyStimulus(1, 2, 1, 0, 0, 0, mk(0, 1, 0, 0, 0, 3, 1));
      applyStimulus(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));

      $display("[TB] mod=10 reps=1 with pause at count 4");
      applyStimulus(1, 10, 1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
      for (int c = 0; c < 4; c++) begin
         applyStimulus(0, 10, 1, 0, 0, 0, mk(1, 0, 0, 4'(c), 0, 0, 1));
      end
      for (int k = 0; k < 3; k++) begin
         applyStimulus(0, 10, 1, 1, 0, 0, mk(1, 0, 0, 4, 0, 0, 1));
      end
      for (int c = 4; c < 10; c++) begin
         applyStimulus(0, 10, 1, 0, 0, 0, mk(1, 0, 0, 4'(c), (c == 9), 0, 1));
      end
      applyStimulus(0, 10, 1, 0, 0, 0, mk(0, 1, 0, 0, 0, 1, 1));
      applyStimulus(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));

      $display("[TB] abort at count 6, then restart with mod=3");
      applyStimulus(1, 10, 2, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
      for (int c = 0; c < 6; c++) begin
         applyStimulus(0, 10, 2, 0, 0, 0, mk(1, 0, 0, 4'(c), 0, 0, 1));
      end
      applyStimulus(0, 10, 2, 0, 1, 0, mk(1, 0, 0, 6, 0, 0, 1));
      applyStimulus(1, 3, 1, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1));
      for (int c = 0; c < 3; c++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, mk(1, 0, 0, 4'(c), (c == 2), 0, 1));
      end
      applyStimulus(0, 0, 0, 0, 0, 0, mk(0, 1, 0, 0, 0, 1, 1));

      $display("[TB] start while busy ignored, reset mid-run at count 7");
      applyStimulus(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
      applyStimulus(1, 10, 2, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0));
      for (int c = 0; c < 8; c++) begin
         applyStimulus((c == 3), (c == 3) ? 4'd5 : 4'd0, (c == 3) ? 8'd1 : 8'd0,
                       0, 0, (c == 7), mk(1, 0, 0, 4'(c), 0, 0, 1));
      end
      applyStimulus(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1));
      applyStimulus(0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1));

      for (int i = 0; i < 10 && scoreQ.size() != 0; i++) begin
         @(negedge clk);
      end
      if (scoreQ.size() != 0) begin
         checks++;
         failures++;
         $display("[TB] FAIL drain pending=%0d expected=0", scoreQ.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
